// File: rtl/video_timing.sv
// Raster timing generator: cascaded horizontal/vertical counters with
// registered blanking, sync and frame-event strobes. Flags are decoded from
// the next-state counts so they always line up with the counts they describe.
module video_timing #(
  parameter int unsigned H_TOTAL        = 384,
  parameter int unsigned H_ACTIVE       = 256,
  parameter int unsigned H_SYNC_START   = 288,
  parameter int unsigned H_SYNC_END     = 320,
  parameter int unsigned V_TOTAL        = 264,
  parameter int unsigned V_ACTIVE_START = 16,
  parameter int unsigned V_ACTIVE_END   = 240,
  parameter int unsigned V_SYNC_START   = 244,
  parameter int unsigned V_SYNC_END     = 247
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic       vbl_irq
);

  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
  localparam logic [8:0] H_SYN_S = 9'(H_SYNC_START);
  localparam logic [8:0] H_SYN_E = 9'(H_SYNC_END);
  localparam logic [8:0] V_ACT_S = 9'(V_ACTIVE_START);
  localparam logic [8:0] V_ACT_E = 9'(V_ACTIVE_END);
  localparam logic [8:0] V_SYN_S = 9'(V_SYNC_START);
  localparam logic [8:0] V_SYN_E = 9'(V_SYNC_END);

  function automatic logic dec_hblank(input logic [8:0] h);
    return h >= H_ACT;
  endfunction

  function automatic logic dec_hsync(input logic [8:0] h);
    return (h >= H_SYN_S) && (h < H_SYN_E);
  endfunction

  function automatic logic dec_vblank(input logic [8:0] v);
    return (v < V_ACT_S) || (v >= V_ACT_E);
  endfunction

  function automatic logic dec_vsync(input logic [8:0] v);
    return (v >= V_SYN_S) && (v < V_SYN_E);
  endfunction

  logic       h_wrap;
  logic       v_wrap;
  logic [8:0] h_nxt;
  logic [8:0] v_nxt;

  // Next-state counts: the horizontal wrap is the only carry into vcnt.
  always_comb begin
    h_wrap = (hcnt == H_LAST);
    v_wrap = (vcnt == V_LAST);
    h_nxt  = h_wrap ? 9'd0 : hcnt + 9'd1;
    v_nxt  = vcnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 9'd0 : vcnt + 9'd1;
    end
  end

  // Counters, level flags and one-clk event pulses; pulses self-clear every clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= 9'd0;
      vcnt        <= 9'd0;
      hblank      <= 1'b0;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vbl_irq     <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vbl_irq     <= 1'b0;
      if (ce_pix) begin
        hcnt        <= h_nxt;
        vcnt        <= v_nxt;
        hblank      <= dec_hblank(h_nxt);
        hsync       <= dec_hsync(h_nxt);
        vblank      <= dec_vblank(v_nxt);
        vsync       <= dec_vsync(v_nxt);
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
        vbl_irq     <= h_wrap && (v_nxt == V_ACT_E);
      end
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Testbench for video_timing: full horizontal timing, shortened vertical
// timing so whole frames fit in a short run. The reference is a plain count
// of pixel strobes since reset, from which every output is derived.
module tb_video_timing;

  localparam int unsigned H_TOTAL        = 384;
  localparam int unsigned H_ACTIVE       = 256;
  localparam int unsigned H_SYNC_START   = 288;
  localparam int unsigned H_SYNC_END     = 320;
  localparam int unsigned V_TOTAL        = 20;
  localparam int unsigned V_ACTIVE_START = 2;
  localparam int unsigned V_ACTIVE_END   = 16;
  localparam int unsigned V_SYNC_START   = 17;
  localparam int unsigned V_SYNC_END     = 19;
  localparam int unsigned FRAME          = H_TOTAL * V_TOTAL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic       hblank, vblank, hsync, vsync;
  logic       line_start, frame_start, vbl_irq;

  int tests = 0;
  int fails = 0;

  video_timing #(
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
    .V_TOTAL(V_TOTAL), .V_ACTIVE_START(V_ACTIVE_START),
    .V_ACTIVE_END(V_ACTIVE_END), .V_SYNC_START(V_SYNC_START),
    .V_SYNC_END(V_SYNC_END)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hcnt(hcnt), .vcnt(vcnt),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .vbl_irq(vbl_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference state: strobes since reset, and whether the last edge was a strobe.
  int unsigned n;
  bit          last_strobe;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n           <= 0;
      last_strobe <= 1'b0;
    end else begin
      last_strobe <= ce_pix;
      if (ce_pix) n <= n + 1;
    end
  end

  // Every-cycle comparison against the strobe-count reference.
  always @(negedge clk) begin
    int unsigned eh, ev;
    bit          els;
    eh  = n % H_TOTAL;
    ev  = (n / H_TOTAL) % V_TOTAL;
    els = last_strobe && (eh == 0);
    chk("m_hcnt",   int'(hcnt), int'(eh));
    chk("m_vcnt",   int'(vcnt), int'(ev));
    chk("m_hblank", int'(hblank), int'(eh >= H_ACTIVE));
    chk("m_hsync",  int'(hsync), int'(eh >= H_SYNC_START && eh < H_SYNC_END));
    chk("m_vblank", int'(vblank), int'(ev < V_ACTIVE_START || ev >= V_ACTIVE_END));
    chk("m_vsync",  int'(vsync), int'(ev >= V_SYNC_START && ev < V_SYNC_END));
    chk("m_line_start",  int'(line_start), int'(els));
    chk("m_frame_start", int'(frame_start), int'(els && ev == 0));
    chk("m_vbl_irq",     int'(vbl_irq), int'(els && ev == V_ACTIVE_END));
  end

  initial begin
    int irqs;
    bit found;

    // Reset values
    reset  = 1'b1;
    ce_pix = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hcnt", int'(hcnt), 0);
    chk("rst_vcnt", int'(vcnt), 0);
    chk("rst_vblank", int'(vblank), 1);
    chk("rst_hblank", int'(hblank), 0);
    chk("rst_line_start", int'(line_start), 0);

    // First strobe after release
    reset  = 1'b0;
    ce_pix = 1'b1;
    @(negedge clk);
    chk("first_hcnt", int'(hcnt), 1);
    chk("first_vcnt", int'(vcnt), 0);
    chk("first_vblank", int'(vblank), 1);
    chk("first_hblank", int'(hblank), 0);
    chk("first_line_start", int'(line_start), 0);

    // One full line with hand-computed horizontal edges
    for (int k = 2; k <= int'(H_TOTAL); k++) begin
      @(negedge clk);
      if (k == 255) chk("hblank_255", int'(hblank), 0);
      if (k == 256) chk("hblank_256", int'(hblank), 1);
      if (k == 287) chk("hsync_287", int'(hsync), 0);
      if (k == 288) chk("hsync_288", int'(hsync), 1);
      if (k == 319) chk("hsync_319", int'(hsync), 1);
      if (k == 320) chk("hsync_320", int'(hsync), 0);
    end
    chk("line_hcnt", int'(hcnt), 0);
    chk("line_vcnt", int'(vcnt), 1);
    chk("line_pulse", int'(line_start), 1);
    ce_pix = 1'b0;
    @(negedge clk);
    chk("line_pulse_clr", int'(line_start), 0);
    chk("hold_hcnt", int'(hcnt), 0);

    // Asynchronous reset mid-frame (hcnt=232, vcnt=3 beforehand)
    ce_pix = 1'b1;
    repeat (1000) @(negedge clk);
    chk("pre_rst_vblank", int'(vblank), 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_hcnt", int'(hcnt), 0);
    chk("arst_vcnt", int'(vcnt), 0);
    chk("arst_vblank", int'(vblank), 1);
    @(negedge clk);
    reset = 1'b0;

    // Full frame from reset with ce_pix tied high
    irqs = 0;
    for (int i = 1; i <= int'(FRAME); i++) begin
      @(negedge clk);
      if (vbl_irq) begin
        irqs++;
        chk("irq_hcnt", int'(hcnt), 0);
        chk("irq_vcnt", int'(vcnt), int'(V_ACTIVE_END));
      end
      if (i == int'(V_ACTIVE_START * H_TOTAL) - 1) chk("vblank_before_fall", int'(vblank), 1);
      if (i == int'(V_ACTIVE_START * H_TOTAL))     chk("vblank_fall", int'(vblank), 0);
      if (i == int'(V_ACTIVE_END * H_TOTAL))       chk("vblank_rise", int'(vblank), 1);
    end
    chk("frame_pulse", int'(frame_start), 1);
    chk("frame_line_pulse", int'(line_start), 1);
    chk("frame_hcnt", int'(hcnt), 0);
    chk("frame_vcnt", int'(vcnt), 0);
    chk("irq_per_frame", irqs, 1);

    // 1-in-4 pixel enable
    for (int i = 0; i < 4000; i++) begin
      ce_pix = (i % 4 == 0);
      @(negedge clk);
    end

    // Random enable with occasional asynchronous resets
    for (int i = 0; i < 20000; i++) begin
      ce_pix = 1'($urandom_range(0, 1));
      if (i % 5000 == 2500) begin
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    // Park at the last pixel of the last line, hold, then wrap both counters
    ce_pix = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < int'(2 * FRAME) && !found; i++) begin
      if (n % FRAME == FRAME - 1) found = 1'b1;
      else @(negedge clk);
    end
    ce_pix = 1'b0;
    chk("park_found", int'(found), 1);
    chk("park_hcnt", int'(hcnt), int'(H_TOTAL - 1));
    chk("park_vcnt", int'(vcnt), int'(V_TOTAL - 1));
    repeat (1000) @(negedge clk);
    chk("held_hcnt", int'(hcnt), int'(H_TOTAL - 1));
    chk("held_vcnt", int'(vcnt), int'(V_TOTAL - 1));
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    chk("wrap_hcnt", int'(hcnt), 0);
    chk("wrap_vcnt", int'(vcnt), 0);
    chk("wrap_frame_start", int'(frame_start), 1);
    chk("wrap_line_start", int'(line_start), 1);
    @(negedge clk);
    chk("wrap_frame_clr", int'(frame_start), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
